// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
//   rf_state_e : init-sweep / run state encoding
//   aw(n)      : address width for an n-entry file
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  function automatic int aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the issue/write-back logic (master) and the register file (slave).
//   ready              : file initialised and usable
//   rd_addr/rd_data    : NRD combinational read ports, port i at [i*W +: W]
//   rd_busy            : per read port, register has an outstanding producer
//   wr_en/wr_addr/data : NWR write-back ports, higher index = younger
//   iss_en/iss_addr    : mark an issuing instruction's destination busy
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) ();

  localparam int AW = aw(NREGS);

  logic                 ready;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for issue-stage hazard detection.
//   clk, rstn : clock, synchronous active-low reset (drops all pending bits)
//   run       : file is in normal operation; bits are frozen otherwise
//   wr_en/wr_addr : write-back ports, each clears its destination
//   iss_en/iss_addr : issuing instruction, sets its destination
//   busy      : current busy vector, bit 0 always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = aw(NREGS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Clears first, then the set: a same-cycle issue to a register being written
  // back belongs to the newer producer and must stay busy.
  always_comb begin
    busy_nxt = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q <= '0;
    end else if (run) begin
      busy_q <= busy_nxt;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, busy scoreboard and a
// self-initialising sweep after reset.
//   clk, rstn : clock, synchronous active-low reset (restarts the sweep)
//   bus       : slave side of regfile_mp_if (reads, write-backs, issue, ready)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_INIT  | sweeping one register per cycle; ports ignored, reads 0
//   S_RUN   | normal operation
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int SP_IDX  = 2,
  parameter int SP_INIT = 512
) (
  input  logic         clk,
  input  logic         rstn,
  regfile_mp_if.slave  bus
);

  localparam int AW = aw(NREGS);
  localparam logic [0:0] S_INIT = RF_INIT;
  localparam logic [0:0] S_RUN  = RF_RUN;

  logic [0:0]      state;
  logic [AW-1:0]   init_ptr;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic            run;

  logic [AW-1:0]   rd_a;
  logic [XLEN-1:0] rd_v;
  logic            rd_hit;

  assign run       = (state == S_RUN);
  assign bus.ready = run;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_INIT;
      init_ptr <= '0;
    end else if (state == S_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == AW'(NREGS - 1)) state <= S_RUN;
    end
  end

  // The array has no reset of its own; the sweep provides known contents.
  // Later loop iterations override earlier ones, so the highest port wins.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (state == S_INIT) begin
        regs[init_ptr] <= (init_ptr == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != '0)
            regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    rd_a   = '0;
    rd_v   = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rd_a   = bus.rd_addr[i*AW +: AW];
      rd_v   = regs[rd_a];
      rd_hit = 1'b0;
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == rd_a) begin
          rd_hit = 1'b1;
          rd_v   = bus.wr_data[w*XLEN +: XLEN];
        end
      end
      if (run && rd_a != '0) begin
        bus.rd_data[i*XLEN +: XLEN] = rd_v;
        bus.rd_busy[i]              = busy[rd_a] & ~rd_hit;
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .run      (run),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  regfile_mp dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    bus.rd_addr[p*5 +: 5] = a;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    bus.wr_en[p]             = 1'b1;
    bus.wr_addr[p*5 +: 5]    = a;
    bus.wr_data[p*32 +: 32]  = d;
  endtask

  function automatic logic [31:0] rdd(input int p);
    return bus.rd_data[p*32 +: 32];
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    bus.rd_addr = '0;
    idle();

    // 1: init sweep
    tick();
    tick();
    chk("reset_ready", 32'(bus.ready), 32'd0);
    rstn = 1'b1;
    rd(0, 5'd2);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k < 32) chk($sformatf("init_ready_c%0d", k), 32'(bus.ready), 32'd0);
      else        chk("init_ready_c32", 32'(bus.ready), 32'd1);
      if (k == 5) chk("init_rd_zero", rdd(0), 32'd0);
    end
    rd(0, 5'd2);
    rd(1, 5'd5);
    settle();
    chk("sp_init", rdd(0), 32'd512);
    chk("x5_zero", rdd(1), 32'd0);
    chk("sp_not_busy", 32'(bus.rd_busy[0]), 32'd0);

    // 2: write with bypass, then array read
    wr(0, 5'd7, 32'hDEADBEEF);
    rd(0, 5'd7);
    settle();
    chk("byp_x7", rdd(0), 32'hDEADBEEF);
    tick();
    idle();
    rd(1, 5'd7);
    settle();
    chk("arr_x7", rdd(1), 32'hDEADBEEF);

    // 3: port priority
    wr(0, 5'd9, 32'd1);
    wr(1, 5'd9, 32'd2);
    rd(0, 5'd9);
    settle();
    chk("prio_byp", rdd(0), 32'd2);
    tick();
    idle();
    settle();
    chk("prio_arr", rdd(0), 32'd2);

    // 4: x0 guard
    wr(0, 5'd0, 32'd5);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
    rd(0, 5'd0);
    settle();
    chk("x0_byp_data", rdd(0), 32'd0);
    chk("x0_byp_busy", 32'(bus.rd_busy[0]), 32'd0);
    tick();
    idle();
    settle();
    chk("x0_data", rdd(0), 32'd0);
    chk("x0_busy", 32'(bus.rd_busy[0]), 32'd0);

    // 5: scoreboard
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    tick();
    idle();
    rd(0, 5'd3);
    rd(1, 5'd4);
    settle();
    chk("sb_iss_busy", 32'(bus.rd_busy[0]), 32'd1);
    chk("sb_other_idle", 32'(bus.rd_busy[1]), 32'd0);
    wr(0, 5'd3, 32'h33);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    settle();
    chk("sb_wr_iss_byp", 32'(bus.rd_busy[0]), 32'd0);
    tick();
    idle();
    settle();
    chk("sb_set_wins", 32'(bus.rd_busy[0]), 32'd1);
    wr(1, 5'd3, 32'h44);
    settle();
    chk("sb_clr_byp_busy", 32'(bus.rd_busy[0]), 32'd0);
    chk("sb_clr_byp_data", rdd(0), 32'h44);
    tick();
    idle();
    settle();
    chk("sb_cleared", 32'(bus.rd_busy[0]), 32'd0);
    chk("sb_x3_data", rdd(0), 32'h44);

    // 6: mid-sweep reset; pending busy dropped, INIT writes ignored
    bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
    tick();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rd(0, 5'd7);
    rd(1, 5'd8);
    for (int k = 1; k <= 32; k++) begin
      if (k == 20) begin
        wr(0, 5'd7, 32'h55);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd8;
        settle();
        chk("init_no_byp", rdd(0), 32'd0);
      end
      tick();
      if (k == 31) chk("mid_ready_c31", 32'(bus.ready), 32'd0);
      if (k == 32) chk("mid_ready_c32", 32'(bus.ready), 32'd1);
    end
    idle();
    settle();
    chk("init_wr_ignored", rdd(0), 32'd0);
    chk("init_iss_ignored", 32'(bus.rd_busy[1]), 32'd0);
    rd(0, 5'd6);
    rd(1, 5'd2);
    settle();
    chk("busy_dropped", 32'(bus.rd_busy[0]), 32'd0);
    chk("sp_reinit", rdd(1), 32'd512);
    rd(0, 5'd9);
    settle();
    chk("x9_reswept", rdd(0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
